// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
//   Types and constants shared by the Fibonacci stream generator:
//     - state_e   : run-control states (IDLE / RUN / DONE)
//     - DEF_WIDTH : default data word width of each term
//     - DEF_NW    : default width of the term-index / count field
//     - FIB_F0/F1 : sequence seeds F(0) and F(1)
// ---------------------------------------------------------------------------
package fib_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NW    = 5;

  // Seeds loaded into the datapath when a run starts.
  localparam int FIB_F0 = 0;
  localparam int FIB_F1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fib_stream_if.sv
// ---------------------------------------------------------------------------
// fib_stream_if
//   Bundles the control and valid/ready stream signals of fib_stream.
//
//   Signals:
//     start     : begin a run (sampled only while the block is idle)
//     n         : index of the last requested term, latched on start
//     out_valid : out_data / out_idx / out_last are valid
//     out_ready : consumer accepts the presented term this cycle
//     out_data  : current term F(out_idx)
//     out_idx   : index of the current term
//     out_last  : current term is the final one of the run
//     busy      : block is not idle
//     done      : one-cycle pulse after the final handshake
//     ovf       : sticky, last run ended early on word overflow
//
//   Modports:
//     master : the generator side (fib_stream), drives the stream
//     slave  : the environment side (controller + consumer)
// ---------------------------------------------------------------------------
interface fib_stream_if
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NW    = DEF_NW
);

  logic             start;
  logic [NW-1:0]    n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [NW-1:0]    out_idx;
  logic             out_last;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    input  start, n, out_ready,
    output out_valid, out_data, out_idx, out_last, busy, done, ovf
  );

  modport slave (
    output start, n, out_ready,
    input  out_valid, out_data, out_idx, out_last, busy, done, ovf
  );

endinterface

// File: rtl/fib_dp.sv
// ---------------------------------------------------------------------------
// fib_dp
//   Fibonacci datapath: holds the current term, the next term, an overflow
//   flag for the next term and the term index. A WIDTH+1-bit adder forms
//   the term after next; its carry tells whether that term still fits.
//
//   Ports:
//     clk     : clock, rising edge
//     rst     : synchronous, active-high reset
//     load    : seed the sequence (cur=F(0), nxt=F(1), idx=0)
//     advance : step one term (cur<=nxt, nxt<=cur+nxt, idx<=idx+1)
//     cur     : F(idx)
//     idx     : index of cur
//     nxt_ovf : F(idx+1) does not fit in WIDTH bits
// ---------------------------------------------------------------------------
module fib_dp
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NW    = DEF_NW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] cur,
  output logic [NW-1:0]    idx,
  output logic             nxt_ovf
);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   sum;

  // One extra bit so the carry out is the overflow of the following term.
  // Both operands are exact whenever an advance is allowed, because the
  // controller stops advancing as soon as nxt_ovf is set.
  assign sum = {1'b0, cur} + {1'b0, nxt};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others (cur<=nxt and nxt<=cur+nxt
  // must both see the old cur/nxt).
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      nxt     <= '0;
      nxt_ovf <= 1'b0;
      idx     <= '0;
    end else if (load) begin
      cur     <= WIDTH'(FIB_F0);
      nxt     <= WIDTH'(FIB_F1);
      nxt_ovf <= 1'b0;
      idx     <= '0;
    end else if (advance) begin
      cur     <= nxt;
      nxt     <= sum[WIDTH-1:0];
      nxt_ovf <= sum[WIDTH];
      idx     <= idx + NW'(1);
    end
  end

endmodule

// File: rtl/fib_stream.sv
// ---------------------------------------------------------------------------
// fib_stream
//   On a start command computes F(0)..F(n) and streams each term over a
//   valid/ready handshake. A run ends at idx==n, or earlier when the next
//   term would overflow WIDTH bits; in the early case ovf is raised and
//   stays set until the next accepted start. The overflowing term itself
//   is never presented.
//
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous, active-high reset (aborts a run, no done pulse)
//     bus : fib_stream_if.master, control inputs and stream outputs
// ---------------------------------------------------------------------------
module fib_stream
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NW    = DEF_NW
) (
  input  logic          clk,
  input  logic          rst,
  fib_stream_if.master  bus
);

  state_e           state;
  state_e           state_nxt;

  logic             load;
  logic             advance;
  logic             finish;

  logic [WIDTH-1:0] cur;
  logic [NW-1:0]    idx;
  logic             nxt_ovf;

  logic [NW-1:0]    n_q;
  logic             ovf_q;

  logic             in_run;
  logic             at_end;
  logic             last;
  logic             hs;

  fib_dp #(
    .WIDTH (WIDTH),
    .NW    (NW)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (advance),
    .cur     (cur),
    .idx     (idx),
    .nxt_ovf (nxt_ovf)
  );

  assign in_run = (state == RUN);
  assign at_end = (idx == n_q);
  // A run ends at the requested index or when the next term cannot be
  // represented; both come from registered state, so out_last is stable
  // for as long as the term is held under backpressure.
  assign last   = in_run & (at_end | nxt_ovf);
  assign hs     = in_run & bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath control.
  // NOTE: every signal written here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (last) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latched term count and sticky overflow flag. ovf only reports an early
  // end: a run whose final requested term is also the largest that fits
  // completed normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      n_q   <= bus.n;
      ovf_q <= 1'b0;
    end else if (finish) begin
      ovf_q <= nxt_ovf & ~at_end;
    end
  end

  assign bus.out_valid = in_run;
  assign bus.out_data  = cur;
  assign bus.out_idx   = idx;
  assign bus.out_last  = last;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fib_stream.sv
// ---------------------------------------------------------------------------
// tb_fib_stream
//   Two instances (WIDTH=16 and WIDTH=8, NW=5) share clk/rst. Stimulus
//   tasks push the expected beats of each run, computed by a plain
//   arithmetic Fibonacci model, into a per-instance queue; a monitor on the
//   falling edge pops and compares on every handshake, checks that held
//   terms stay stable under backpressure and checks the done pulse.
// ---------------------------------------------------------------------------
module tb_fib_stream;

  localparam int NW = 5;

  typedef struct {
    longint data;
    int     idx;
    bit     last;
  } exp_t;

  typedef struct {
    bit     v;
    bit     l;
    bit     bz;
    bit     dn;
    bit     ov;
    longint d;
    int     i;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fib_stream_if #(.WIDTH(16), .NW(NW)) b16 ();
  fib_stream_if #(.WIDTH(8),  .NW(NW)) b8  ();

  fib_stream #(.WIDTH(16), .NW(NW)) u16 (.clk(clk), .rst(rst), .bus(b16));
  fib_stream #(.WIDTH(8),  .NW(NW)) u8  (.clk(clk), .rst(rst), .bus(b8));

  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t exp0[$];
  exp_t exp1[$];
  int   exp_cnt [2];
  bit   exp_ovf [2];
  bit   run_active [2];

  // Monitor-owned bookkeeping.
  int     hs_cnt [2];
  int     done_cnt [2];
  bit     prev_stall [2];
  bit     prev_last_hs [2];
  bit     prev_done [2];
  longint prev_d [2];
  int     prev_i [2];
  bit     prev_l [2];

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic snap_t snap(input int s);
    snap_t r;
    if (s == 0) begin
      r.v = b16.out_valid; r.l = b16.out_last; r.bz = b16.busy;
      r.dn = b16.done; r.ov = b16.ovf; r.d = longint'(b16.out_data);
      r.i = int'(b16.out_idx);
    end else begin
      r.v = b8.out_valid; r.l = b8.out_last; r.bz = b8.busy;
      r.dn = b8.done; r.ov = b8.ovf; r.d = longint'(b8.out_data);
      r.i = int'(b8.out_idx);
    end
    return r;
  endfunction

  task automatic drive(input int s, input bit st, input int nn, input bit rd);
    if (s == 0) begin
      b16.start = st; b16.n = NW'(nn); b16.out_ready = rd;
    end else begin
      b8.start = st; b8.n = NW'(nn); b8.out_ready = rd;
    end
  endtask

  // Reference: the terms F(0)..F(n) that fit in 'width' bits, the final one
  // flagged, and whether the run stopped before reaching n.
  task automatic model_run(input int s, input int width, input int n);
    longint lim = longint'(1) << width;
    longint a = 0;
    longint b = 1;
    longint t;
    exp_t   e;
    for (int k = 0; k <= n; k++) begin
      e.data = a;
      e.idx  = k;
      e.last = (k == n) || (b >= lim);
      if (s == 0) exp0.push_back(e); else exp1.push_back(e);
      if (e.last) begin
        exp_ovf[s] = (b >= lim) && (k != n);
        exp_cnt[s] = k + 1;
        break;
      end
      t = a + b;
      a = b;
      b = t;
    end
  endtask

  // One instance's monitor step, evaluated on the falling edge.
  task automatic mon(input int s, input snap_t o, input bit rdy);
    exp_t e;
    int   qs;
    if (rst) begin
      prev_stall[s]   = 1'b0;
      prev_last_hs[s] = 1'b0;
      prev_done[s]    = 1'b0;
      return;
    end
    qs = (s == 0) ? exp0.size() : exp1.size();
    if (prev_stall[s]) begin
      check($sformatf("stall_valid[%0d]", s), o.v, 1);
      check($sformatf("stall_data[%0d]", s), o.d, prev_d[s]);
      check($sformatf("stall_idx[%0d]", s), o.i, prev_i[s]);
      check($sformatf("stall_last[%0d]", s), o.l, prev_l[s]);
    end
    if (o.v && rdy) begin
      check($sformatf("beat_expected[%0d]", s), (qs > 0), 1);
      if (qs > 0) begin
        e = (s == 0) ? exp0.pop_front() : exp1.pop_front();
        check($sformatf("data[%0d] idx %0d", s, e.idx), o.d, e.data);
        check($sformatf("idx[%0d]", s), o.i, e.idx);
        check($sformatf("last[%0d] idx %0d", s, e.idx), o.l, e.last);
      end
      check($sformatf("busy_in_run[%0d]", s), o.bz, 1);
      hs_cnt[s]++;
    end
    if (o.dn) begin
      check($sformatf("done_in_run[%0d]", s), run_active[s], 1);
      check($sformatf("done_single[%0d]", s), prev_done[s], 0);
      check($sformatf("done_after_last[%0d]", s), prev_last_hs[s], 1);
      check($sformatf("done_queue_empty[%0d]", s), qs, 0);
      check($sformatf("done_ovf[%0d]", s), o.ov, exp_ovf[s]);
      check($sformatf("done_busy[%0d]", s), o.bz, 1);
      check($sformatf("done_valid[%0d]", s), o.v, 0);
      done_cnt[s]++;
    end
    prev_stall[s]   = o.v && !rdy;
    prev_last_hs[s] = o.v && rdy && o.l;
    prev_done[s]    = o.dn;
    prev_d[s]       = o.d;
    prev_i[s]       = o.i;
    prev_l[s]       = o.l;
  endtask

  always @(negedge clk) begin
    mon(0, snap(0), b16.out_ready);
    mon(1, snap(1), b8.out_ready);
  end

  // One complete run. Called and returning at posedge+1 with the instance
  // idle. rnd selects random backpressure (stalls of at most 5 cycles);
  // poke_at >= 0 pulses start with a different n at that cycle of the run.
  task automatic do_run(input int s, input int n, input bit rnd, input int poke_at);
    snap_t o;
    int    hs0 = hs_cnt[s];
    int    dn0 = done_cnt[s];
    int    cyc = 0;
    int    stall = 0;
    bit    rd;
    model_run(s, (s == 0) ? 16 : 8, n);
    run_active[s] = 1'b1;
    drive(s, 1'b1, n, 1'b1);
    @(posedge clk); #1;
    drive(s, 1'b0, n, 1'b1);
    o = snap(s);
    check($sformatf("start_valid[%0d]", s), o.v, 1);
    check($sformatf("start_idx[%0d]", s), o.i, 0);
    check($sformatf("start_ovf_clear[%0d]", s), o.ov, 0);
    check($sformatf("start_busy[%0d]", s), o.bz, 1);
    while (done_cnt[s] == dn0 && cyc < 400) begin
      rd = 1'b1;
      if (rnd && stall < 5 && $urandom_range(0, 1) == 1) begin
        rd = 1'b0;
        stall++;
      end else begin
        stall = 0;
      end
      if (cyc == poke_at) drive(s, 1'b1, 3, rd);
      else                drive(s, 1'b0, n, rd);
      @(posedge clk); #1;
      cyc++;
    end
    drive(s, 1'b0, n, 1'b1);
    run_active[s] = 1'b0;
    o = snap(s);
    check($sformatf("done_seen[%0d] n=%0d", s, n), done_cnt[s] - dn0, 1);
    check($sformatf("hs_count[%0d] n=%0d", s, n), hs_cnt[s] - hs0, exp_cnt[s]);
    if (!rnd) check($sformatf("throughput[%0d] n=%0d", s, n), cyc, exp_cnt[s] + 1);
    check($sformatf("busy_after_done[%0d]", s), o.bz, 0);
    check($sformatf("ovf_sticky[%0d]", s), o.ov, exp_ovf[s]);
  endtask

  initial begin
    snap_t o;
    int    cyc;
    int    dn0;
    drive(0, 1'b0, 0, 1'b1);
    drive(1, 1'b0, 0, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      o = snap(s);
      check($sformatf("rst_valid[%0d]", s), o.v, 0);
      check($sformatf("rst_data[%0d]", s), o.d, 0);
      check($sformatf("rst_idx[%0d]", s), o.i, 0);
      check($sformatf("rst_last[%0d]", s), o.l, 0);
      check($sformatf("rst_busy[%0d]", s), o.bz, 0);
      check($sformatf("rst_done[%0d]", s), o.dn, 0);
      check($sformatf("rst_ovf[%0d]", s), o.ov, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    do_run(0, 10, 1'b0, -1);   // 0..55, full speed
    do_run(0, 0,  1'b0, -1);   // single term
    do_run(0, 10, 1'b1, -1);   // random backpressure
    do_run(1, 20, 1'b0, -1);   // 8-bit: stops at 233, ovf
    do_run(1, 3,  1'b0, -1);   // clears ovf, 0,1,1,2
    do_run(0, 31, 1'b0, -1);   // 16-bit: stops at 46368, ovf
    do_run(0, 10, 1'b0, 4);    // start during RUN is ignored

    // Reset in the middle of a run.
    dn0 = done_cnt[0];
    model_run(0, 16, 10);
    run_active[0] = 1'b1;
    drive(0, 1'b1, 10, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 10, 1'b1);
    cyc = 0;
    while (int'(b16.out_idx) != 5 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reach_idx5", int'(b16.out_idx), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    o = snap(0);
    check("midrst_valid", o.v, 0);
    check("midrst_busy", o.bz, 0);
    check("midrst_idx", o.i, 0);
    rst = 1'b0;
    exp0.delete();
    run_active[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt[0] - dn0, 0);
    check("midrst_still_idle", b16.busy, 0);

    // Randomised runs on both widths.
    for (int r = 0; r < 8; r++) begin
      do_run(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 1'b1, -1);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
